// File: rtl/ram_march_bist.sv
// ram_march_bist
//   March C- self-test initiator for one port of a synchronous single-cycle RAM.
//   After an accepted start it issues one RAM operation per clock in this order:
//     M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1), M4 down(r1,w0), M5 down(r0)
//   Here 0 = PATTERN and 1 = ~PATTERN.
//   Every read is checked against its expected background. The first
//   miscompare is captured, and the run always completes.
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            asynchronous active-high reset
//   start_i          begin a test; only honoured in IDLE or DONE
//   busy_o           a test is in progress
//   done_o           test finished; level, cleared by the next accepted start
//   fail_o           sticky: at least one miscompare in the current run
//   fail_addr_o      address of the first miscompare
//   fail_expected_o  expected data of the first miscompare
//   fail_actual_o    read data of the first miscompare
//   ram_addr_o       RAM port address (registered)
//   ram_data_o       RAM port write data (registered, held during reads)
//   ram_we_o         RAM port write enable (registered)
//   ram_q_i          RAM read data, valid one clock after a read is presented
module ram_march_bist #(
  parameter int unsigned           ADDR_WIDTH = 6,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_expected_o,
  output logic [DATA_WIDTH-1:0] fail_actual_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  ram_we_o,
  input  logic [DATA_WIDTH-1:0] ram_q_i
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] BG0        = PATTERN;
  localparam logic [DATA_WIDTH-1:0] BG1        = ~PATTERN;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_M0    = 4'd1,
    S_M1    = 4'd2,
    S_M2    = 4'd3,
    S_M3    = 4'd4,
    S_M4    = 4'd5,
    S_M5    = 4'd6,
    S_FLUSH = 4'd7,
    S_DONE  = 4'd8
  } state_e;

  // The state, phase and ram_* registers describe the operation currently on the RAM port.
  state_e                  state_q, state_d;
  logic                    phase_q, phase_d;      // r,w elements: 0 = read slot, 1 = write slot
  logic [ADDR_WIDTH-1:0]   ram_addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   ram_data_q, data_d;
  logic                    ram_we_q, we_d;
  logic                    rd_q, rd_d;            // current port operation is a checked read
  logic [DATA_WIDTH-1:0]   rd_exp_q, exp_d;       // background expected from that read
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    clear_d;               // accepted start: wipe result registers

  // Compare pipeline: stage 1 is the RAM access cycle; at the next edge ram_q_i is checked.
  logic                    cmp_valid_q;
  logic [ADDR_WIDTH-1:0]   cmp_addr_q;
  logic [DATA_WIDTH-1:0]   cmp_exp_q;
  logic                    mismatch;

  logic                    fail_q;
  logic [ADDR_WIDTH-1:0]   fail_addr_q;
  logic [DATA_WIDTH-1:0]   fail_exp_q;
  logic [DATA_WIDTH-1:0]   fail_act_q;

  // Next-operation sequencer and decode of the operation to drive after this edge.
  always_comb begin
    state_d = state_q;
    phase_d = 1'b0;
    addr_d  = ram_addr_q;
    clear_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_M0;
          addr_d  = ADDR_FIRST;
          clear_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_M0: begin
        if (ram_addr_q == ADDR_LAST) begin
          state_d = S_M1;
          addr_d  = ADDR_FIRST;
        end else begin
          addr_d  = ram_addr_q + ADDR_STEP;
        end
      end
      S_M1, S_M2: begin
        if (!phase_q) begin
          phase_d = 1'b1;                       // write back to the address just read
        end else if (ram_addr_q == ADDR_LAST) begin
          state_d = (state_q == S_M1) ? S_M2 : S_M3;
          addr_d  = (state_q == S_M1) ? ADDR_FIRST : ADDR_LAST;
        end else begin
          addr_d  = ram_addr_q + ADDR_STEP;
        end
      end
      S_M3, S_M4: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (ram_addr_q == ADDR_FIRST) begin
          state_d = (state_q == S_M3) ? S_M4 : S_M5;
          addr_d  = ADDR_LAST;
        end else begin
          addr_d  = ram_addr_q - ADDR_STEP;
        end
      end
      S_M5: begin
        if (ram_addr_q == ADDR_FIRST) begin
          state_d = S_FLUSH;                    // last read still in the compare pipe
        end else begin
          addr_d  = ram_addr_q - ADDR_STEP;
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reads leave ram_data on its last value.
    we_d   = 1'b0;
    data_d = ram_data_q;
    rd_d   = 1'b0;
    exp_d  = rd_exp_q;
    case (state_d)
      S_M0: begin
        we_d   = 1'b1;
        data_d = BG0;
      end
      S_M1, S_M3: begin
        if (phase_d) begin
          we_d   = 1'b1;
          data_d = BG1;
        end else begin
          rd_d   = 1'b1;
          exp_d  = BG0;
        end
      end
      S_M2, S_M4: begin
        if (phase_d) begin
          we_d   = 1'b1;
          data_d = BG0;
        end else begin
          rd_d   = 1'b1;
          exp_d  = BG1;
        end
      end
      S_M5: begin
        rd_d  = 1'b1;
        exp_d = BG0;
      end
      default: begin
        we_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // FSM state and registered RAM port / status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      ram_addr_q <= {ADDR_WIDTH{1'b0}};
      ram_data_q <= {DATA_WIDTH{1'b0}};
      ram_we_q   <= 1'b0;
      rd_q       <= 1'b0;
      rd_exp_q   <= {DATA_WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      ram_addr_q <= addr_d;
      ram_data_q <= data_d;
      ram_we_q   <= we_d;
      rd_q       <= rd_d;
      rd_exp_q   <= exp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Track each read while the RAM services it, so ram_q_i can be checked one edge later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= {ADDR_WIDTH{1'b0}};
      cmp_exp_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      cmp_valid_q <= rd_q;
      cmp_addr_q  <= ram_addr_q;
      cmp_exp_q   <= rd_exp_q;
    end
  end

  assign mismatch = cmp_valid_q && (ram_q_i != cmp_exp_q);

  // Sticky fail flag plus first-miscompare capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fail_q      <= 1'b0;
      fail_addr_q <= {ADDR_WIDTH{1'b0}};
      fail_exp_q  <= {DATA_WIDTH{1'b0}};
      fail_act_q  <= {DATA_WIDTH{1'b0}};
    end else if (clear_d) begin
      // No read is pending when a start is accepted, so clearing never drops a compare.
      fail_q      <= 1'b0;
      fail_addr_q <= {ADDR_WIDTH{1'b0}};
      fail_exp_q  <= {DATA_WIDTH{1'b0}};
      fail_act_q  <= {DATA_WIDTH{1'b0}};
    end else if (mismatch) begin
      fail_q <= 1'b1;
      if (!fail_q) begin
        fail_addr_q <= cmp_addr_q;
        fail_exp_q  <= cmp_exp_q;
        fail_act_q  <= ram_q_i;
      end
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign fail_o          = fail_q;
  assign fail_addr_o     = fail_addr_q;
  assign fail_expected_o = fail_exp_q;
  assign fail_actual_o   = fail_act_q;
  assign ram_addr_o      = ram_addr_q;
  assign ram_data_o      = ram_data_q;
  assign ram_we_o        = ram_we_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist.
// DUT A uses PATTERN 8'h00 and a RAM model with selectable faults.
// DUT B uses PATTERN 8'h55 and a fault-free RAM.
module tb_ram_march_bist;

  logic       clk;
  logic       rst;
  logic       start_a;
  logic       start_b;
  int         nvec;
  int         nfail;
  int         fault;   // 0 none, 1 bit3 stuck-at-0 at 0x15, 2 writes to 0x3F also hit 0x00

  logic       busy_a, done_a, fail_a, ram_we_a;
  logic [5:0] fail_addr_a, ram_addr_a;
  logic [7:0] fail_exp_a, fail_act_a, ram_data_a, q_a;
  logic       busy_b, done_b, fail_b, ram_we_b;
  logic [5:0] fail_addr_b, ram_addr_b;
  logic [7:0] fail_exp_b, fail_act_b, ram_data_b, q_b;

  logic [7:0] mem_a [0:63];
  logic [7:0] mem_b [0:63];

  ram_march_bist #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .PATTERN(8'h00)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a),
    .busy_o(busy_a), .done_o(done_a), .fail_o(fail_a),
    .fail_addr_o(fail_addr_a), .fail_expected_o(fail_exp_a), .fail_actual_o(fail_act_a),
    .ram_addr_o(ram_addr_a), .ram_data_o(ram_data_a), .ram_we_o(ram_we_a),
    .ram_q_i(q_a)
  );

  ram_march_bist #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .PATTERN(8'h55)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b),
    .busy_o(busy_b), .done_o(done_b), .fail_o(fail_b),
    .fail_addr_o(fail_addr_b), .fail_expected_o(fail_exp_b), .fail_actual_o(fail_act_b),
    .ram_addr_o(ram_addr_b), .ram_data_o(ram_data_b), .ram_we_o(ram_we_b),
    .ram_q_i(q_b)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM behind DUT A: one-cycle read, write-through, optional injected fault.
  always @(posedge clk) begin
    if (ram_we_a) begin
      mem_a[ram_addr_a] <= ram_data_a;
      if (fault == 2 && ram_addr_a == 6'h3F) mem_a[0] <= ram_data_a;
      q_a <= ram_data_a;
    end else begin
      if (fault == 1 && ram_addr_a == 6'h15) q_a <= mem_a[ram_addr_a] & 8'hF7;
      else q_a <= mem_a[ram_addr_a];
    end
  end

  // RAM behind DUT B: fault-free.
  always @(posedge clk) begin
    if (ram_we_b) begin
      mem_b[ram_addr_b] <= ram_data_b;
      q_b <= ram_data_b;
    end else begin
      q_b <= mem_b[ram_addr_b];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected operation k of a 64-word March C- run: {we, addr, write data}.
  function automatic logic [14:0] exp_op(input int k, input logic [7:0] pat);
    int j;
    logic we;
    logic [5:0] a;
    logic [7:0] d;
    we = 1'b0; a = 6'd0; d = pat; j = 0;
    if (k < 64) begin
      we = 1'b1; a = 6'(k); d = pat;
    end else if (k < 192) begin
      j = k - 64;  a = 6'(j / 2);      we = (j % 2 == 1); d = ~pat;
    end else if (k < 320) begin
      j = k - 192; a = 6'(j / 2);      we = (j % 2 == 1); d = pat;
    end else if (k < 448) begin
      j = k - 320; a = 6'(63 - j / 2); we = (j % 2 == 1); d = ~pat;
    end else if (k < 576) begin
      j = k - 448; a = 6'(63 - j / 2); we = (j % 2 == 1); d = pat;
    end else begin
      a = 6'(639 - k); we = 1'b0;
    end
    return {we, a, d};
  endfunction

  // One full run on DUT A (optionally B). It checks every port operation and the
  // done timing, and returns just after E641.
  task automatic run_test(input bit with_b, input bit poke, input bit hold);
    int wr_n;
    int rd_n;
    logic [7:0]  last_a;
    logic [7:0]  last_b;
    logic [14:0] ea;
    logic [14:0] eb;
    wr_n = 0; rd_n = 0; last_a = 8'h00; last_b = 8'h00;
    @(negedge clk);
    start_a = 1'b1;
    start_b = with_b;
    for (int k = 0; k < 640; k++) begin
      @(negedge clk);
      start_a = hold | (poke & (k == 100));
      start_b = 1'b0;
      if (k == 0) check("busy_rise", 32'(busy_a), 32'd1);
      ea = exp_op(k, 8'h00);
      if (ea[14]) last_a = ea[7:0];
      check("opA", {17'd0, ram_we_a, ram_addr_a, ram_data_a}, {17'd0, ea[14:8], last_a});
      if (ram_we_a) wr_n++;
      else rd_n++;
      if (with_b) begin
        eb = exp_op(k, 8'h55);
        if (eb[14]) last_b = eb[7:0];
        check("opB", {17'd0, ram_we_b, ram_addr_b, ram_data_b}, {17'd0, eb[14:8], last_b});
      end
    end
    check("write_count", 32'(wr_n), 32'd320);
    check("read_count", 32'(rd_n), 32'd320);
    @(negedge clk);
    check("flush_busy_done", {30'd0, busy_a, done_a}, 32'h2);
    @(negedge clk);
    check("e641_busy_done", {30'd0, busy_a, done_a}, 32'h1);
    if (with_b) check("e641_busy_done_B", {30'd0, busy_b, done_b}, 32'h1);
  endtask

  // Directed test sequence.
  initial begin
    nvec = 0; nfail = 0; fault = 0;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctl", {28'd0, busy_a, done_a, fail_a, ram_we_a}, 32'd0);
    check("reset_bus", {18'd0, ram_addr_a, ram_data_a}, 32'd0);
    check("reset_cap", {10'd0, fail_addr_a, fail_exp_a, fail_act_a}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy_a), 32'd0);

    // Fault-free A with start poke mid-run; B with PATTERN 0x55 in parallel.
    run_test(1'b1, 1'b1, 1'b0);
    check("pass_A", {9'd0, fail_a, fail_addr_a, fail_exp_a, fail_act_a}, 32'd0);
    check("pass_B", {9'd0, fail_b, fail_addr_b, fail_exp_b, fail_act_b}, 32'd0);

    // Bit 3 stuck-at-0 at 0x15: first seen on the M2 read.
    fault = 1;
    run_test(1'b0, 1'b0, 1'b0);
    check("stuck_fail", {9'd0, fail_a, fail_addr_a, fail_exp_a, fail_act_a},
          {9'd0, 1'b1, 6'h15, 8'hFF, 8'hF7});

    // Alias 0x3F -> 0x00: first seen on the M3 read of 0x00.
    fault = 2;
    run_test(1'b0, 1'b0, 1'b0);
    check("alias_fail", {9'd0, fail_a, fail_addr_a, fail_exp_a, fail_act_a},
          {9'd0, 1'b1, 6'h00, 8'h00, 8'hFF});

    // Start held high through DONE: the edge after DONE restarts and clears results.
    fault = 1;
    run_test(1'b0, 1'b0, 1'b1);
    check("hold_fail_at_done", 32'(fail_a), 32'd1);
    @(negedge clk);
    start_a = 1'b0;
    check("restart_status", {29'd0, busy_a, done_a, fail_a}, 32'h4);
    check("restart_cap", {10'd0, fail_addr_a, fail_exp_a, fail_act_a}, 32'd0);
    check("restart_op0", {17'd0, ram_we_a, ram_addr_a, ram_data_a}, {17'd0, 1'b1, 6'h00, 8'h00});

    // Reset near cycle 300 of the restarted run.
    repeat (298) @(negedge clk);
    check("pre_reset_fail", {30'd0, busy_a, fail_a}, 32'h3);
    #1 rst = 1'b1;
    #1;
    check("async_reset_ctl", {28'd0, busy_a, done_a, fail_a, ram_we_a}, 32'd0);
    check("async_reset_bus", {18'd0, ram_addr_a, ram_data_a}, 32'd0);
    check("async_reset_cap", {10'd0, fail_addr_a, fail_exp_a, fail_act_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fault = 0;
    @(negedge clk);
    check("post_reset_idle", {30'd0, busy_a, done_a}, 32'd0);
    run_test(1'b0, 1'b0, 1'b0);
    check("after_reset_pass", {9'd0, fail_a, fail_addr_a, fail_exp_a, fail_act_a}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/ram_march_bist.md
# ram_march_bist

March C- built-in self-test controller that acts as the initiator for a single port of the team's synchronous 64×8 dual-port RAM. On `start` it drives address, write data and write enable, checks every read against the expected background pattern, and reports pass or fail with the first failing address and data. It sits between a test/debug controller and one RAM port, muxed in ahead of the functional master.

## Interface
- `ADDR_WIDTH`, 6, RAM address width; DEPTH = 2**ADDR_WIDTH.
- `DATA_WIDTH`, 8, RAM word width.
- `PATTERN`, 8'h00, data background "0"; "1" is ~PATTERN.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: begin test; sampled only when not busy.
- `busy` output 1: test in progress.
- `done` output 1: test complete; level, held until next accepted start.
- `fail` output 1: sticky, at least one miscompare in the current run.
- `fail_addr` output ADDR_WIDTH: address of first miscompare.
- `fail_expected` output DATA_WIDTH: expected data of first miscompare.
- `fail_actual` output DATA_WIDTH: read data of first miscompare.
- `ram_addr` output ADDR_WIDTH: RAM port address, registered.
- `ram_data` output DATA_WIDTH: RAM port write data, registered.
- `ram_we` output 1: RAM port write enable, registered.
- `ram_q` input DATA_WIDTH: RAM port read data; valid one clock after the address is presented with `ram_we`=0.

## Operation
- States: IDLE, M0..M5, FLUSH, DONE.
- March elements, with 0 = PATTERN and 1 = ~PATTERN:
  - M0 ⇑(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇓(r0)
- Addressing: ⇑ runs 0→DEPTH-1 and ⇓ runs DEPTH-1→0. The address counter wraps to the start address of the next element.
- Issue rate: one RAM operation per clock, with no idle cycles between operations or elements.
  - r,w elements use 2 clocks per address: read, then write at the same address.
  - w-only and r-only elements use 1 clock per address.
- During reads, `ram_we`=0 and `ram_data` holds its last value.
- Compare path:
  - Each read pushes {valid, addr, expected} into a 2-stage pipeline.
  - `ram_q` is compared at the stage-2 edge.
  - A mismatch sets `fail`. On the first mismatch only, it captures `fail_addr`, `fail_expected` and `fail_actual`.
  - The test always runs to completion; it never aborts on failure.
- FLUSH: after the last M5 read, wait for the final compare, then go to DONE.
- Start acceptance:
  - `start` is accepted in IDLE or DONE and ignored while busy.
  - An accepted start clears `done`, `fail` and the capture registers at the accepting edge.
  - `start` held high continuously restarts immediately after each DONE.
- Reset values: all outputs 0, state IDLE. `ram_we` deasserts asynchronously on `rst`. Reset mid-run leaves RAM contents undefined.

## Timing
- E0 is the edge that accepts `start`. Operation k (k=0..10·DEPTH-1) is driven on the RAM port in the cycle after edge Ek.
- `busy` rises after E0.
- First write: `ram_we`=1, `ram_addr`=0, `ram_data`=PATTERN, driven after E0.
- Read issued after Ek: RAM captures it at Ek+1 and the block compares at Ek+2.
- DEPTH=64: 640 operations (320 writes, 320 reads). The last read is issued after E639 and compared at E641.
- At E641 `busy` falls and `done` rises in the same edge (10·DEPTH+1 edges after E0). `fail` and the capture registers are final at that same edge.
- M1/M2 word: r0 (or r1) at addr a after Ek, then w1 (or w0) at addr a after Ek+1.

## Test plan
- **Fault-free RAM model** (1-cycle read, write-through on write), pulse `start` → `busy` after E0; `done`=1, `busy`=0 at E641; `fail`=0; exactly 320 writes and 320 reads observed.
- **Bit 3 stuck-at-0 at addr 0x15** → `fail`=1 with `fail_addr`=0x15, `fail_expected`=0xFF, `fail_actual`=0xF7 (first seen in M2); `done` still at E641.
- **Address alias** (writes to 0x3F also write 0x00) → first fail in M3 with `fail_addr`=0x00, `fail_expected`=0x00, `fail_actual`=0xFF.
- **PATTERN=8'h55, fault-free** → M0 writes 0x55, M1 writes 0xAA; pass; `done` at E641.
- **Reset and restart**: `rst` pulsed at cycle 300 → `busy`, `ram_we` and all outputs 0 immediately; a new `start` then runs a full 641-edge test and passes.
- **Start while busy / start held high**: `start` pulse at cycle 100 of a run → ignored, `done` still at E641. `start` held high → a new run is accepted at the edge after DONE and clears `done` and `fail`.
